// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame-format encodings and helpers
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam logic [1:0] DATA_BITS_5 = 2'b00;
  localparam logic [1:0] DATA_BITS_6 = 2'b01;
  localparam logic [1:0] DATA_BITS_7 = 2'b10;
  localparam logic [1:0] DATA_BITS_8 = 2'b11;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic [3:0] data_bits(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchronizer for the async serial line, resets to idle-high
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '1;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with one-entry holding register and rts_n flow control
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rts_n
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  rx_state_e     state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          pbit;
  logic          ferr;
  logic          stop_cnt;
  logic [1:0]    cfg_bits;
  logic          cfg_stop;
  logic          cfg_par_en;
  logic          cfg_par_type;
  logic          rx_s;
  logic [3:0]    n_bits;
  logic          centre;
  logic          frame_end;
  logic          perr_now;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    n_bits    = data_bits(cfg_bits);
    centre    = tick && (tick_cnt == LAST);
    frame_end = (state == STOP) && centre && (stop_cnt || !cfg_stop);
    perr_now  = cfg_par_en & (^shift_reg ^ pbit ^ cfg_par_type);
  end

  // Frame sequencing; every count and sample is qualified by tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      pbit         <= 1'b0;
      ferr         <= 1'b0;
      stop_cnt     <= 1'b0;
      cfg_bits     <= DATA_BITS_8;
      cfg_stop     <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_par_type <= PARITY_EVEN;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state        <= START;
            tick_cnt     <= '0;
            cfg_bits     <= data_bit_num;
            cfg_stop     <= stop_bit_num;
            cfg_par_en   <= parity_en;
            cfg_par_type <= parity_type;
          end
        end
        START: begin
          if (tick_cnt == MID) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state     <= DATA;
              tick_cnt  <= '0;
              bit_cnt   <= '0;
              shift_reg <= '0;
              pbit      <= 1'b0;
              ferr      <= 1'b0;
              stop_cnt  <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == LAST) begin
            tick_cnt           <= '0;
            shift_reg[bit_cnt] <= rx_s;
            bit_cnt            <= bit_cnt + 1'b1;
            if ({1'b0, bit_cnt} == n_bits - 4'd1) state <= cfg_par_en ? PARITY : STOP;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (tick_cnt == LAST) begin
            tick_cnt <= '0;
            pbit     <= rx_s;
            state    <= STOP;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == LAST) begin
            tick_cnt <= '0;
            if (!rx_s) ferr <= 1'b1;
            // Leave at the centre of the last stop bit so a back-to-back start edge is seen.
            if (cfg_stop && !stop_cnt) stop_cnt <= 1'b1;
            else                       state    <= IDLE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_done     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      rts_n       <= 1'b1;
    end else begin
      rx_done <= 1'b0;
      rts_n   <= rx_valid;
      if (frame_end) begin
        if (!rx_valid || rd_en) begin
          rx_data    <= shift_reg;
          parity_err <= perr_now;
          frame_err  <= ferr | ~rx_s;
          rx_valid   <= 1'b1;
          rx_done    <= 1'b1;
          if (rx_valid) overrun_err <= 1'b0;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rd_en && rx_valid) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx with a frame scoreboard
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 256;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       rx;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rts_n;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   tcnt     = 0;

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .rx           (rx),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .rd_en        (rd_en),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_done      (rx_done),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .rts_n        (rts_n)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % 16;
      tick = (tcnt == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_done === 1'b1) begin
      exp_t e;
      done_cnt++;
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed=rx_done data %0h expected=no frame", rx_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_data", rx_data, e.data);
        check("sb_perr", parity_err, e.perr);
        check("sb_ferr", frame_err, e.ferr);
        check("sb_valid", rx_valid, 1);
      end
    end
  end

  task automatic hold(input int clks);
    repeat (clks) @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] bits, input logic stop2, input logic pen, input logic ptype);
    data_bit_num = bits;
    stop_bit_num = stop2;
    parity_en    = pen;
    parity_type  = ptype;
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen, input logic pbit,
                            input logic stop2, input logic s1, input logic s2);
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      rx = data[i];
      hold(BIT_CLKS);
    end
    if (pen) begin
      rx = pbit;
      hold(BIT_CLKS);
    end
    rx = s1;
    hold(BIT_CLKS);
    if (stop2) begin
      rx = s2;
      hold(BIT_CLKS);
    end
    rx = 1'b1;
  endtask

  task automatic consume;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int  base;
    bit  hit;
    rst_n = 1'b0;
    rx    = 1'b1;
    rd_en = 1'b0;
    cfg(DATA_BITS_8, 1'b0, 1'b1, PARITY_EVEN);
    hold(4);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rts_n", rts_n, 1);
    check("rst_errs", {parity_err, frame_err, overrun_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rts_after_rst", rts_n, 0);
    hold(BIT_CLKS);

    // 8E1, 0xA5, good parity
    sb.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    hold(BIT_CLKS);
    check("t1_valid", rx_valid, 1);
    check("t1_rts_n", rts_n, 1);
    consume();
    check("t1_rts_clear", rts_n, 0);

    // 8O1, 0xA5 with even parity bit -> parity error
    cfg(DATA_BITS_8, 1'b0, 1'b1, PARITY_ODD);
    sb.push_back('{data: 8'hA5, perr: 1'b1, ferr: 1'b0});
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    hold(BIT_CLKS);
    check("t2_perr", parity_err, 1);
    consume();
    check("t2_valid_clr", rx_valid, 0);
    check("t2_perr_clr", parity_err, 0);
    check("t2_rts_n", rts_n, 0);

    // 5N2, 0x15, second stop bit low
    cfg(DATA_BITS_5, 1'b1, 1'b0, PARITY_EVEN);
    sb.push_back('{data: 8'h15, perr: 1'b0, ferr: 1'b1});
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(2 * BIT_CLKS);
    check("t3_upper_zero", rx_data[7:5], 0);
    check("t3_ferr", frame_err, 1);
    consume();

    // 4-tick glitch then a good 8N1 0x3C
    cfg(DATA_BITS_8, 1'b0, 1'b0, PARITY_EVEN);
    base = done_cnt;
    rx = 1'b0;
    hold(64);
    rx = 1'b1;
    hold(2 * BIT_CLKS);
    check("t4_no_done", done_cnt, base);
    check("t4_idle", dut.state, IDLE);
    sb.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    hold(BIT_CLKS);
    check("t4_valid", rx_valid, 1);
    consume();

    // back-to-back 0x11, 0x22 with no read -> overrun
    base = done_cnt;
    sb.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    hold(BIT_CLKS);
    check("t5_held", rx_data, 8'h11);
    check("t5_overrun", overrun_err, 1);
    check("t5_one_done", done_cnt, base + 1);
    consume();
    check("t5_overrun_clr", overrun_err, 0);

    // repeat with rd_en on the second completion clock
    sb.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    sb.push_back('{data: 8'h22, perr: 1'b0, ferr: 1'b0});
    hit = 0;
    fork
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 12 * BIT_CLKS && !hit; i++) begin
          @(negedge clk);
          if (dut.frame_end) begin
            hit = 1;
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
          end
        end
      end
    join
    check("t5_rd_hit", hit, 1);
    hold(BIT_CLKS);
    check("t5_new_data", rx_data, 8'h22);
    check("t5_no_overrun", overrun_err, 0);

    // reset during data bit 3, with a frame still held
    rx = 1'b0;
    hold(BIT_CLKS);
    rx = 1'b0; hold(BIT_CLKS);
    rx = 1'b1; hold(BIT_CLKS);
    rx = 1'b0; hold(BIT_CLKS);
    rx = 1'b1; hold(BIT_CLKS / 2);
    rst_n = 1'b0;
    hold(2);
    check("t6_rx_data", rx_data, 0);
    check("t6_valid", rx_valid, 0);
    check("t6_rts_n", rts_n, 1);
    check("t6_errs", {parity_err, frame_err, overrun_err, rx_done}, 0);
    check("t6_state", dut.state, IDLE);
    rst_n = 1'b1;
    hold(2 * BIT_CLKS);
    check("t6_rts_ready", rts_n, 0);
    sb.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    hold(BIT_CLKS);
    check("t6_data", rx_data, 8'h5A);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
